booth_mpy: RTL and testbench



---
 rtl/booth_mpy_pkg.sv | 15 +
 rtl/booth_mpy_step.sv | 41 ++++
 rtl/booth_mpy.sv | 106 ++++++++++
 tb/tb_booth_mpy.sv | 133 +++++++++++++
 4 files changed

// File: rtl/booth_mpy_pkg.sv
// Shared widths and FSM encoding for the sequential Booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package booth_mpy_pkg;

    localparam int WIDTH  = 32;   // operand width
    localparam int PWIDTH = 64;   // product width
    localparam int STEPS  = 32;   // one Booth step per multiplier bit

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/booth_mpy_step.sv
// One radix-2 Booth iteration: recode {acc_lo[0], q_m1}, add/sub the
// multiplicand into the upper accumulator, then arithmetic-shift right by 1.
// Latency: combinational. Backpressure: none.
//
// Ports:
//   acc_hi, acc_lo, q_m1 : current Booth state
//   m                    : multiplicand (two's complement)
//   acc_hi_nxt, acc_lo_nxt, q_m1_nxt : state after this step
module booth_step
    import booth_mpy_pkg::*;
(
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One guard bit keeps the subtraction of -2^31 from overflowing.
    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = acc_hi;
        case ({acc_lo[0], q_m1})
            2'b01:   sum = acc_hi + m_ext;
            2'b10:   sum = acc_hi - m_ext;
            default: sum = acc_hi;
        endcase
    end

    // Arithmetic shift of {sum, acc_lo, q_m1}, replicating the guard bit.
    assign acc_hi_nxt = {sum[WIDTH], sum[WIDTH:1]};
    assign acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    assign q_m1_nxt   = acc_lo[0];

endmodule

// File: rtl/booth_mpy.sv
// Free-running 32x32 signed Booth multiplier; restarts whenever {a,b} change.
// Latency: product updates 32 cycles after the edge that latches new operands.
// Backpressure: none; the consumer waits >= 33 cycles after changing operands.
//
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   a, b    : signed multiplicand / multiplier
//   product : registered signed 64-bit result, only updated on completion
module booth_mpy
    import booth_mpy_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [PWIDTH-1:0] product
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             q_m1;
    logic [5:0]       cnt;

    logic [WIDTH:0]   acc_hi_nxt;
    logic [WIDTH-1:0] acc_lo_nxt;
    logic             q_m1_nxt;

    logic change;
    logic last_step;
    logic done;

    // Any operand difference restarts the sequence, even mid-run.
    assign change    = ({a, b} != {op_a, op_b});
    assign last_step = (cnt == 6'(STEPS - 1));
    assign done      = (state == RUN) && !change && last_step;

    booth_step u_step (
        .acc_hi     (acc_hi),
        .acc_lo     (acc_lo),
        .q_m1       (q_m1),
        .m          (op_a),
        .acc_hi_nxt (acc_hi_nxt),
        .acc_lo_nxt (acc_lo_nxt),
        .q_m1_nxt   (q_m1_nxt)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (change) state_nxt = RUN;
            end
            RUN: begin
                if (change)         state_nxt = RUN;
                else if (last_step) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on change, otherwise step while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (change) begin
            op_a   <= a;
            op_b   <= b;
            acc_hi <= '0;
            acc_lo <= b;
            q_m1   <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc_hi <= acc_hi_nxt;
            acc_lo <= acc_lo_nxt;
            q_m1   <= q_m1_nxt;
            cnt    <= cnt + 6'd1;
            // The exact product always fits in 64 bits, so the guard bit
            // is redundant here and dropped.
            if (done) begin
                product <= {acc_hi_nxt[WIDTH-1:0], acc_lo_nxt};
            end
        end
    end

endmodule

// File: tb/tb_booth_mpy.sv
module tb_booth_mpy;
    import booth_mpy_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;

    int          n_vec;
    int          n_bad;
    logic [63:0] last;

    booth_mpy dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Apply operands, check the old result holds through edge k+31 and the
    // new one appears at edge k+32, then hold out to a 100-cycle window.
    task automatic mpy(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [63:0] exp);
        a = ia;
        b = ib;
        tick();                 // load edge k
        repeat (31) tick();
        chk({tag, "_hold"}, product, last);
        tick();                 // edge k+32
        chk(tag, product, exp);
        repeat (67) tick();
        chk({tag, "_end"}, product, exp);
        last = exp;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        longint      e;

        n_vec = 0;
        n_bad = 0;
        last  = '0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;

        // Reset
        repeat (2) tick();
        chk("rst_product", product, 64'd0);
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (10) tick();
            chk("idle_zero", product, 64'd0);
        end
        chk("idle_state", 64'(dut.state), 64'(IDLE));

        // Basic and corner cases
        mpy("3x-5",      32'd3,          32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        mpy("min_x_min", 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000);
        mpy("max_x_max", 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        mpy("min_x_1",   32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000);
        mpy("min_x_max", 32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        mpy("0_x_n",     32'd0,          32'd12345,     64'd0);
        mpy("-1_x_-1",   32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'd1);

        // Mid-run change: 1000*1000 must never surface
        a = 32'd1000;
        b = 32'd1000;
        tick();                 // first load
        repeat (9) tick();
        a = 32'hFFFF_FFF9;      // -7
        b = 32'd9;
        tick();                 // second load
        for (int i = 0; i < 31; i++) begin
            tick();
            if (product === 64'd1000000) chk("mid_stale", product, last);
        end
        chk("mid_hold", product, last);
        tick();
        chk("mid_-63", product, 64'hFFFF_FFFF_FFFF_FFC1);
        repeat (20) tick();
        chk("mid_end", product, 64'hFFFF_FFFF_FFFF_FFC1);

        // Reset mid-run
        a = 32'd12345;
        b = 32'hFFFF_FFFE;      // -2
        tick();                 // load
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_zero", product, 64'd0);
        chk("rstmid_state", 64'(dut.state), 64'(IDLE));
        tick();                 // operands re-detected, reload
        repeat (31) tick();
        chk("rstmid_hold", product, 64'd0);
        tick();                 // 33 cycles after rst deasserted
        chk("rstmid_res", product, 64'hFFFF_FFFF_FFFF_9F8E);
        last = 64'hFFFF_FFFF_FFFF_9F8E;

        // Random sweep
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            e  = longint'($signed(ra)) * longint'($signed(rb));
            mpy("rand", ra, rb, 64'(e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
